// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor with a
// valid/ready stream interface. The N-bit operation is cut into N/BLK
// blocks. Each pipeline stage resolves one BLK-bit block with a flat
// lookahead carry network. The block carry-out is registered for the next
// stage, so the critical path does not depend on N.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid        in_ready  pipeline accepts this cycle
//   A, B       N-bit operands        c_in      carry-in / borrow-in
//   sub        1: A - B - c_in, 0: A + B + c_in
//   out_valid  result valid          out_ready consumer accepts result
//   S          N-bit result          c_out     carry out (sub: 1 = no borrow)
//   ovf        signed two's-complement overflow
module cla_pipe_adder #(
  parameter int N   = 32,
  parameter int BLK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] S,
  output logic         c_out,
  output logic         ovf
);

  localparam int NSTG = N / BLK;

  // Index k of these arrays is the input side of stage k. Index 0 is the
  // transformed operand port, and index k+1 is the register bank of stage k.
  logic [N-1:0] a_w [NSTG+1];
  logic [N-1:0] b_w [NSTG+1];
  logic [N-1:0] s_w [NSTG+1];
  logic [NSTG:0] c_w;
  logic [NSTG:0] v_w;
  logic [NSTG-1:0] ld;

  // Returns {carry_out, sum}. Each carry is written in two-level
  // sum-of-products form over (g, p, ci), not rippled through lower carries.
  function automatic logic [BLK:0] cla_blk(input logic [BLK-1:0] a,
                                           input logic [BLK-1:0] b,
                                           input logic ci);
    logic [BLK-1:0] g;
    logic [BLK-1:0] p;
    logic [BLK:0]   c;
    logic           t;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < BLK; i++) begin
      t = ci;
      for (int j = 0; j <= i; j++) t = t & p[j];
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        c[i+1] = c[i+1] | t;
      end
    end
    return {c[BLK], p ^ c[BLK-1:0]};
  endfunction

  // Subtraction becomes A + ~B + ~c_in, so the borrow-in turns into an inverted carry-in.
  assign a_w[0] = A;
  assign b_w[0] = sub ? ~B : B;
  assign c_w[0] = c_in ^ sub;
  assign s_w[0] = '0;
  assign v_w[0] = in_valid;

  // A stage may load when it is empty or when its content moves on. The
  // chain runs from the output back to the input, so in_ready can follow
  // out_ready in the same cycle.
  always_comb begin
    ld = '0;
    ld[NSTG-1] = ~v_w[NSTG] | out_ready;
    for (int k = NSTG - 2; k >= 0; k--) ld[k] = ~v_w[k+1] | ld[k+1];
  end

  assign in_ready = ld[0] & rst_n;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic [BLK:0]   cla_d;
    logic [N-1:0]   s_d;
    logic           dat_en;

    assign cla_d  = cla_blk(a_w[k][k*BLK +: BLK], b_w[k][k*BLK +: BLK], c_w[k]);
    assign dat_en = ld[k] & v_w[k];

    always_comb begin
      s_d = s_w[k];
      s_d[k*BLK +: BLK] = cla_d[BLK-1:0];
    end

    if (k < NSTG - 1) begin : g_mid
      // ---- stage k -> stage k+1 boundary ----
      logic         v_q;
      logic         c_q;
      logic [N-1:0] s_q;
      logic [N-1:0] a_q;
      logic [N-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     v_q <= 1'b0;
        else if (ld[k]) v_q <= v_w[k];
      end

      always_ff @(posedge clk) begin
        if (dat_en) begin
          s_q <= s_d;
          a_q <= a_w[k];
          b_q <= b_w[k];
          c_q <= cla_d[BLK];
        end
      end

      assign v_w[k+1] = v_q;
      assign c_w[k+1] = c_q;
      assign s_w[k+1] = s_q;
      assign a_w[k+1] = a_q;
      assign b_w[k+1] = b_q;
    end else begin : g_last
      // ---- last stage -> output boundary ----
      logic         v_q;
      logic         c_q;
      logic         o_q;
      logic [N-1:0] s_q;
      logic         o_d;

      // Same-sign operands giving an opposite-sign result is exactly the
      // case where the carries into and out of bit N-1 differ.
      assign o_d = (a_w[k][N-1] ~^ b_w[k][N-1]) & (cla_d[BLK-1] ^ a_w[k][N-1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          o_q <= 1'b0;
          s_q <= '0;
        end else begin
          if (ld[k]) v_q <= v_w[k];
          if (dat_en) begin
            s_q <= s_d;
            c_q <= cla_d[BLK];
            o_q <= o_d;
          end
        end
      end

      assign v_w[k+1] = v_q;
      assign c_w[k+1] = c_q;
      assign s_w[k+1] = s_q;
      assign a_w[k+1] = '0;
      assign b_w[k+1] = '0;
      assign ovf      = o_q;
    end
  end

  assign out_valid = v_w[NSTG];
  assign S         = s_w[NSTG];
  assign c_out     = c_w[NSTG];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Testbench for cla_pipe_adder. Three instances are built:
// (N=32, BLK=8), (N=16, BLK=4) and (N=8, BLK=8).
// Expected results come from a plain-arithmetic model. Each model result is
// pushed on acceptance and popped when the design emits a result.
module tb_cla_pipe_adder;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        iv   [3];
  logic        ir   [3];
  logic        ci   [3];
  logic        sb   [3];
  logic        ov   [3];
  logic        ordy [3];
  logic        co   [3];
  logic        of   [3];
  logic [31:0] a_d  [3];
  logic [31:0] b_d  [3];
  logic [31:0] s_o  [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic, reduced modulo 2^n.
  function automatic exp_t model(input int n, input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic s);
    longint one, m, half, ua, ub, sa, sbv, cv, ur, sr;
    exp_t   e;
    one  = 1;
    m    = (one << n) - 1;
    half = one << (n - 1);
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    sa   = (ua >= half) ? ua - (one << n) : ua;
    sbv  = (ub >= half) ? ub - (one << n) : ub;
    cv   = c ? 1 : 0;
    if (s) begin
      ur  = ua - ub - cv;
      sr  = sa - sbv - cv;
      e.c = (ua >= ub + cv);
    end else begin
      ur  = ua + ub + cv;
      sr  = sa + sbv + cv;
      e.c = ((ur >> n) & 1) != 0;
    end
    e.s = 32'(ur & m);
    e.o = (sr >= half) || (sr < -half);
    return e;
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int NW = (i == 0) ? 32 : ((i == 1) ? 16 : 8);
    localparam int BW = (i == 1) ? 4 : 8;

    logic [NW-1:0] s_w;
    logic          hold = 1'b0;
    logic [31:0]   hs;
    logic          hc;
    logic          ho;
    exp_t          q[$];
    exp_t          e;

    cla_pipe_adder #(.N(NW), .BLK(BW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[i]),
      .in_ready  (ir[i]),
      .A         (a_d[i][NW-1:0]),
      .B         (b_d[i][NW-1:0]),
      .c_in      (ci[i]),
      .sub       (sb[i]),
      .out_valid (ov[i]),
      .out_ready (ordy[i]),
      .S         (s_w),
      .c_out     (co[i]),
      .ovf       (of[i])
    );

    assign s_o[i] = 32'(s_w);

    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk($sformatf("i%0d held valid", i), 32'(ov[i]), 32'd1);
          chk($sformatf("i%0d held S", i), s_o[i], hs);
          chk($sformatf("i%0d held c_out", i), 32'(co[i]), 32'(hc));
          chk($sformatf("i%0d held ovf", i), 32'(of[i]), 32'(ho));
        end
        if (ov[i] && ordy[i]) begin
          chk($sformatf("i%0d result expected", i), 32'(q.size() > 0), 32'd1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("i%0d S", i), s_o[i], e.s);
            chk($sformatf("i%0d c_out", i), 32'(co[i]), 32'(e.c));
            chk($sformatf("i%0d ovf", i), 32'(of[i]), 32'(e.o));
          end
        end
        hold = ov[i] && !ordy[i];
        hs   = s_o[i];
        hc   = co[i];
        ho   = of[i];
        if (iv[i] && ir[i]) q.push_back(model(NW, a_d[i], b_d[i], ci[i], sb[i]));
      end
    end
  end

  function automatic int qsize(input int i);
    case (i)
      0:       return g_dut[0].q.size();
      1:       return g_dut[1].q.size();
      default: return g_dut[2].q.size();
    endcase
  endfunction

  function automatic int lat(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  // One operation into an empty pipe. Checks the exact latency and the values.
  task automatic send_chk(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic s, input logic [31:0] es,
                          input logic ec, input logic eo, input string tag);
    @(posedge clk); #1;
    a_d[i] = a; b_d[i] = b; ci[i] = c; sb[i] = s; iv[i] = 1'b1; ordy[i] = 1'b1;
    @(negedge clk);
    chk({tag, " in_ready"}, 32'(ir[i]), 32'd1);
    @(posedge clk); #1;
    iv[i] = 1'b0;
    for (int j = 0; j < lat(i) - 1; j++) begin
      @(negedge clk);
      chk({tag, " early valid"}, 32'(ov[i]), 32'd0);
    end
    @(negedge clk);
    chk({tag, " valid"}, 32'(ov[i]), 32'd1);
    chk({tag, " S"}, s_o[i], es);
    chk({tag, " c_out"}, 32'(co[i]), 32'(ec));
    chk({tag, " ovf"}, 32'(of[i]), 32'(eo));
  endtask

  task automatic drain(input int i);
    int t;
    t = 0;
    @(posedge clk); #1;
    iv[i] = 1'b0; ordy[i] = 1'b1;
    while ((qsize(i) != 0 || ov[i]) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("i%0d drain left", i), 32'(qsize(i)), 32'd0);
    chk($sformatf("i%0d drain valid", i), 32'(ov[i]), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; ci[i] = 1'b0; sb[i] = 1'b0;
      a_d[i] = '0; b_d[i] = '0;
    end

    // Reset state
    #1 rst_n = 1'b0;
    #11;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("i%0d rst out_valid", i), 32'(ov[i]), 32'd0);
      chk($sformatf("i%0d rst S", i), s_o[i], 32'd0);
      chk($sformatf("i%0d rst c_out", i), 32'(co[i]), 32'd0);
      chk($sformatf("i%0d rst ovf", i), 32'(of[i]), 32'd0);
      chk($sformatf("i%0d rst in_ready", i), 32'(ir[i]), 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("i%0d idle in_ready", i), 32'(ir[i]), 32'd1);
      chk($sformatf("i%0d idle out_valid", i), 32'(ov[i]), 32'd0);
    end

    // Directed arithmetic corners
    send_chk(0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, "carry out");
    send_chk(0, 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, "5-7");
    send_chk(0, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, "min-1");
    send_chk(0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, "max+1");
    send_chk(0, 32'h00000005, 32'h00000002, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0, "5-2-1");
    send_chk(1, 32'h00007FFF, 32'h00000001, 1'b0, 1'b0, 32'h00008000, 1'b0, 1'b1, "n16 max+1");
    send_chk(1, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, "n16 carry");
    send_chk(2, 32'h0000007F, 32'h00000001, 1'b0, 1'b0, 32'h00000080, 1'b0, 1'b1, "n8 max+1");
    send_chk(2, 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, "n8 carry");
    drain(0); drain(1); drain(2);

    // Back-to-back streaming with out_ready held high
    for (int j = 0; j < 200; j++) begin
      @(posedge clk); #1;
      iv[0] = 1'b1; ordy[0] = 1'b1;
      a_d[0] = $urandom; b_d[0] = $urandom;
      ci[0] = 1'($urandom); sb[0] = 1'($urandom);
      @(negedge clk);
      chk("stream in_ready", 32'(ir[0]), 32'd1);
      if (j >= lat(0)) chk("stream out_valid", 32'(ov[0]), 32'd1);
    end
    drain(0);

    // Backpressure: output stalled, input kept valid
    acc = 0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      iv[0] = 1'b1; ordy[0] = 1'b0;
      a_d[0] = $urandom; b_d[0] = $urandom;
      ci[0] = 1'($urandom); sb[0] = 1'($urandom);
      @(negedge clk);
      chk("bp in_ready", 32'(ir[0]), 32'(j < 4));
      if (ir[0]) acc++;
    end
    chk("bp accepted", 32'(acc), 32'd4);
    chk("bp out_valid", 32'(ov[0]), 32'd1);
    drain(0);

    // Reset with three operations in flight
    @(posedge clk); #1;
    ordy[0] = 1'b1; iv[0] = 1'b1; ci[0] = 1'b0; sb[0] = 1'b0;
    a_d[0] = 32'h00001234; b_d[0] = 32'h00001111;
    @(posedge clk); #1 a_d[0] = 32'h00000005; b_d[0] = 32'h00000003;
    @(posedge clk); #1 a_d[0] = 32'h000000A0; b_d[0] = 32'h0000000B;
    @(posedge clk); #1 iv[0] = 1'b0;
    @(posedge clk); #2;
    chk("mid pre valid", 32'(ov[0]), 32'd1);
    chk("mid pre S", s_o[0], 32'h00002345);
    rst_n = 1'b0;
    #1;
    chk("mid rst valid", 32'(ov[0]), 32'd0);
    chk("mid rst S", s_o[0], 32'd0);
    chk("mid rst c_out", 32'(co[0]), 32'd0);
    chk("mid rst ovf", 32'(of[0]), 32'd0);
    chk("mid rst in_ready", 32'(ir[0]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid rst hold in_ready", 32'(ir[0]), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post rst in_ready", 32'(ir[0]), 32'd1);
    repeat (6) begin
      @(negedge clk);
      chk("no stale result", 32'(ov[0]), 32'd0);
    end
    send_chk(0, 32'h00000010, 32'h00000003, 1'b0, 1'b1, 32'h0000000D, 1'b1, 1'b0, "post rst");
    drain(0);

    // Random traffic with random backpressure on all three widths
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        iv[i]   = ($urandom_range(3) != 0);
        ordy[i] = ($urandom_range(2) != 0);
        a_d[i]  = ($urandom_range(7) == 0) ? 32'hFFFFFFFF : $urandom;
        b_d[i]  = $urandom;
        ci[i]   = 1'($urandom);
        sb[i]   = 1'($urandom);
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1;
    end
    drain(0); drain(1); drain(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
